cpu_divmod_unit: RTL and testbench

CPU_DIVMOD_UNIT -- requirements
Module: cpu_divmod_unit

---
 rtl/cpu_divmod_unit.sv | 169 ++++++++++++++++
 tb/tb_cpu_divmod_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divmod_unit.sv
// cpu_divmod_unit
// ---------------
// Multi-cycle integer divide/remainder unit for the CPU execute stage.
// A command is captured in IDLE, the operands are turned into magnitudes in
// PREP, a restoring radix-2 divider produces one quotient bit per cycle in
// ITER, and FIX applies the sign correction and publishes the result.
//
// Parameters
//   WIDTH          operand/result width in bits (2..64)
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   enable         global stall; 0 freezes every register in the unit
//   start          command request, honoured only while idle and enabled
//   unsgn_or_sgn   0 = unsigned divide, 1 = two's-complement signed divide
//   num            dividend
//   denom          divisor
//   quot           registered quotient
//   rem            registered remainder
//   can_accept_cmd high while idle; a start this cycle is taken
//   data_ready     one-cycle pulse when quot/rem/div_by_zero are fresh
//   div_by_zero    the last result came from a zero divisor
module cpu_divmod_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             unsgn_or_sgn,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] denom,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             can_accept_cmd,
  output logic             data_ready,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] numRaw_q;
  logic [WIDTH-1:0] denRaw_q;
  logic             sgn_q;
  logic [WIDTH-1:0] numMag_q;
  logic [WIDTH-1:0] denMag_q;
  logic [WIDTH-1:0] remPart_q;
  logic             negQuot_q;
  logic             negRem_q;
  logic             zeroDen_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             dataReady_q;

  logic [WIDTH-1:0] numAbs_d;
  logic [WIDTH-1:0] denAbs_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   diff_d;
  logic             qBit_d;
  logic [WIDTH-1:0] remStep_d;
  logic [WIDTH-1:0] quotFix_d;
  logic [WIDTH-1:0] remFix_d;

  // Datapath for one divider step and for the final sign fix-up.
  // numMag_q doubles as the quotient register: dividend bits leave at the
  // top while quotient bits enter at the bottom. The partial remainder is
  // always below the divisor, so the shifted value minus the divisor fits in
  // WIDTH+1 bits and its top bit is a clean borrow flag. The magnitude of the
  // most-negative number is 2^(WIDTH-1), which still fits unsigned, so the
  // signed-overflow case falls out of the normal path without special casing.
  always_comb begin
    numAbs_d  = (sgn_q && numRaw_q[WIDTH-1]) ? (-numRaw_q) : numRaw_q;
    denAbs_d  = (sgn_q && denRaw_q[WIDTH-1]) ? (-denRaw_q) : denRaw_q;
    shifted_d = {remPart_q, numMag_q[WIDTH-1]};
    diff_d    = shifted_d - {1'b0, denMag_q};
    qBit_d    = ~diff_d[WIDTH];
    remStep_d = qBit_d ? diff_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    if (zeroDen_q) begin
      quotFix_d = '1;
      remFix_d  = numRaw_q;
    end else begin
      quotFix_d = negQuot_q ? (-numMag_q) : numMag_q;
      remFix_d  = negRem_q ? (-remPart_q) : remPart_q;
    end
  end

  // Control FSM with the operand, working and result registers.
  // data_ready is cleared on every enabled edge except the one leaving FIX,
  // so a pulse raised just before a stall stays visible until the pipeline
  // moves again. Because FIX returns straight to IDLE, the unit can accept a
  // new command in the same cycle that it reports the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      numRaw_q    <= '0;
      denRaw_q    <= '0;
      sgn_q       <= 1'b0;
      numMag_q    <= '0;
      denMag_q    <= '0;
      remPart_q   <= '0;
      negQuot_q   <= 1'b0;
      negRem_q    <= 1'b0;
      zeroDen_q   <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      dataReady_q <= 1'b0;
    end else if (enable) begin
      dataReady_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            numRaw_q <= num;
            denRaw_q <= denom;
            sgn_q    <= unsgn_or_sgn;
            state_q  <= PREP;
          end
        end
        PREP: begin
          numMag_q  <= numAbs_d;
          denMag_q  <= denAbs_d;
          negQuot_q <= sgn_q & (numRaw_q[WIDTH-1] ^ denRaw_q[WIDTH-1]);
          negRem_q  <= sgn_q & numRaw_q[WIDTH-1];
          remPart_q <= '0;
          cnt_q     <= CNT_LAST;
          zeroDen_q <= (denRaw_q == '0);
          state_q   <= (denRaw_q == '0) ? FIX : ITER;
        end
        ITER: begin
          remPart_q <= remStep_d;
          numMag_q  <= {numMag_q[WIDTH-2:0], qBit_d};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          quot_q      <= quotFix_d;
          rem_q       <= remFix_d;
          dbz_q       <= zeroDen_q;
          dataReady_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quot           = quot_q;
  assign rem            = rem_q;
  assign div_by_zero    = dbz_q;
  assign data_ready     = dataReady_q;
  assign can_accept_cmd = (state_q == IDLE);

endmodule

// File: tb/tb_cpu_divmod_unit.sv
// tb_cpu_divmod_unit
// ------------------
// Self-checking bench for cpu_divmod_unit. A 32-bit instance carries the
// directed and random traffic; a 64-bit instance covers the wide
// all-ones / 1 case. Expected results come from plain integer arithmetic.
module tb_cpu_divmod_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        start;
  logic        unsgn_or_sgn;
  logic [31:0] num;
  logic [31:0] denom;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        can_accept_cmd;
  logic        data_ready;
  logic        div_by_zero;

  logic        start64;
  logic [63:0] num64;
  logic [63:0] denom64;
  logic [63:0] quot64;
  logic [63:0] rem64;
  logic        canAccept64;
  logic        dataReady64;
  logic        divByZero64;

  int testCount;
  int failCount;

  cpu_divmod_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .start          (start),
    .unsgn_or_sgn   (unsgn_or_sgn),
    .num            (num),
    .denom          (denom),
    .quot           (quot),
    .rem            (rem),
    .can_accept_cmd (can_accept_cmd),
    .data_ready     (data_ready),
    .div_by_zero    (div_by_zero)
  );

  cpu_divmod_unit #(.WIDTH(64)) dut64 (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .start          (start64),
    .unsgn_or_sgn   (1'b0),
    .num            (num64),
    .denom          (denom64),
    .quot           (quot64),
    .rem            (rem64),
    .can_accept_cmd (canAccept64),
    .data_ready     (dataReady64),
    .div_by_zero    (divByZero64)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: zero divisor gives all ones and the dividend back;
  // otherwise ordinary truncating division, done in 64-bit signed
  // arithmetic for signed mode so that -2^31 / -1 wraps to -2^31.
  function automatic void refModel(input logic sg, input logic [31:0] n,
                                   input logic [31:0] d, output logic [31:0] q,
                                   output logic [31:0] r, output logic z);
    longint sn;
    longint sd;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = n;
      z = 1'b1;
    end else if (!sg) begin
      q = n / d;
      r = n % d;
      z = 1'b0;
    end else begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      q  = 32'(sn / sd);
      r  = 32'(sn % sd);
      z  = 1'b0;
    end
  endfunction

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one command on the 32-bit unit and follow it to data_ready.
  // Called at #1 after a rising edge with the unit idle. stallAt/stallLen
  // drop enable for a window; busyStartAt pulses a stray start while busy.
  // When checkClear is 0 the task returns in the data_ready cycle.
  task automatic applyStimulus(input string tag, input logic sg,
                               input logic [31:0] n, input logic [31:0] d,
                               input int stallAt, input int stallLen,
                               input int busyStartAt, input bit checkClear);
    logic [31:0] expQ;
    logic [31:0] expR;
    logic        expZ;
    int          expLat;
    int          cycles;
    refModel(sg, n, d, expQ, expR, expZ);
    expLat = (d == 32'd0) ? 2 : 34;
    if (stallAt >= 0) expLat += stallLen;
    checkOutput({tag, ".canAccept"}, 64'(can_accept_cmd), 64'd1);
    unsgn_or_sgn = sg;
    num          = n;
    denom        = d;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (data_ready !== 1'b1 && cycles < 200) begin
      if (cycles == stallAt) enable = 1'b0;
      if (stallAt >= 0 && cycles == stallAt + stallLen) enable = 1'b1;
      if (cycles == busyStartAt) begin
        start        = 1'b1;
        num          = 32'd5;
        denom        = 32'd0;
        unsgn_or_sgn = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    enable = 1'b1;
    start  = 1'b0;
    checkOutput({tag, ".latency"}, 64'(cycles), 64'(expLat));
    checkOutput({tag, ".quot"}, 64'(quot), 64'(expQ));
    checkOutput({tag, ".rem"}, 64'(rem), 64'(expR));
    checkOutput({tag, ".dbz"}, 64'(div_by_zero), 64'(expZ));
    if (checkClear) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".pulseClear"}, 64'(data_ready), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rn;
    logic [31:0] rd;
    logic        rs;
    logic [31:0] heldQ;
    int          pulses;
    int          cycles;

    testCount    = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    start        = 1'b0;
    unsgn_or_sgn = 1'b0;
    num          = '0;
    denom        = '0;
    start64      = 1'b0;
    num64        = '0;
    denom64      = '0;

    // Reset applies even with enable low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.quot", 64'(quot), 64'd0);
    checkOutput("reset.rem", 64'(rem), 64'd0);
    checkOutput("reset.dbz", 64'(div_by_zero), 64'd0);
    checkOutput("reset.ready", 64'(data_ready), 64'd0);
    checkOutput("reset.canAccept", 64'(can_accept_cmd), 64'd1);
    checkOutput("reset.canAccept64", 64'(canAccept64), 64'd1);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    applyStimulus("udiv100_7", 1'b0, 32'd100, 32'd7, -1, 0, -1, 1'b1);
    applyStimulus("sdivNeg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, -1, 1'b1);
    applyStimulus("sdiv7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1, 0, -1, 1'b1);
    applyStimulus("udivZero", 1'b0, 32'h1234_5678, 32'd0, -1, 0, -1, 1'b1);
    applyStimulus("sdivZero", 1'b1, 32'h1234_5678, 32'd0, -1, 0, -1, 1'b1);
    applyStimulus("sOverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, -1, 1'b1);
    applyStimulus("uMaxByOne", 1'b0, 32'hFFFF_FFFF, 32'd1, -1, 0, -1, 1'b1);

    // Stall during ITER plus a stray start while busy.
    applyStimulus("stallBusy", 1'b0, 32'd123456, 32'd789, 10, 5, 6, 1'b1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (data_ready === 1'b1) pulses++;
    end
    checkOutput("stallBusy.noQueued", 64'(pulses), 64'd0);

    // A pending data_ready stays high while stalled, then clears.
    applyStimulus("readyFreeze", 1'b1, 32'hFFFF_FF9C, 32'd9, -1, 0, -1, 1'b0);
    heldQ  = quot;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("readyFreeze.held", 64'(data_ready), 64'd1);
    checkOutput("readyFreeze.quotHeld", 64'(quot), 64'(heldQ));
    enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyFreeze.cleared", 64'(data_ready), 64'd0);

    // Back-to-back: the second start is raised in the data_ready cycle.
    applyStimulus("b2bFirst", 1'b0, 32'd1000, 32'd33, -1, 0, -1, 1'b0);
    applyStimulus("b2bSecond", 1'b1, 32'hFFFF_FC18, 32'd7, -1, 0, -1, 1'b1);

    // Reset in the middle of ITER aborts without a result.
    num          = 32'd1000;
    denom        = 32'd3;
    unsgn_or_sgn = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midReset.quot", 64'(quot), 64'd0);
    checkOutput("midReset.rem", 64'(rem), 64'd0);
    checkOutput("midReset.dbz", 64'(div_by_zero), 64'd0);
    checkOutput("midReset.ready", 64'(data_ready), 64'd0);
    rst_n = 1'b1;
    checkOutput("midReset.canAccept", 64'(can_accept_cmd), 64'd1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (data_ready === 1'b1) pulses++;
    end
    checkOutput("midReset.noPulse", 64'(pulses), 64'd0);

    // Random traffic mixed with boundary-shaped operands.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      rn = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: rd = 32'($urandom_range(1, 15));
        2: rd = 32'd0;
        3: begin
          rn = 32'h8000_0000;
          rd = 32'hFFFF_FFFF;
        end
        4: rd = 32'hFFFF_FFFF;
        default: begin
          rd = 32'($urandom_range(100, 1000));
          rn = 32'($urandom_range(0, 99));
        end
      endcase
      applyStimulus($sformatf("rand%0d", i), rs, rn, rd, -1, 0, -1, 1'b0);
      @(posedge clk);
      #1;
    end

    // 64-bit instance: all ones divided by one.
    num64   = 64'hFFFF_FFFF_FFFF_FFFF;
    denom64 = 64'd1;
    start64 = 1'b1;
    @(posedge clk);
    #1;
    start64 = 1'b0;
    cycles  = 0;
    while (dataReady64 !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("w64.latency", 64'(cycles), 64'd66);
    checkOutput("w64.quot", quot64, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("w64.rem", rem64, 64'd0);
    checkOutput("w64.dbz", 64'(divByZero64), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
